// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline control blocks: forwarding selects,
// hazard FSM states and the hard-wired zero register.
package pipeline_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear beats an increment in the same cycle.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall / taken-branch flush control for ID/EX and IF/ID, plus
// registered EX forwarding selects and stall/flush event counters.
module hazard_forward_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             idex_MemRead,
  input  logic             idex_RegWrite,
  input  logic [REG_W-1:0] idex_wreg,
  input  logic             exmem_RegWrite,
  input  logic [REG_W-1:0] exmem_wreg,
  input  logic             ex_branch_taken,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [REG_W-1:0] ZERO_R = REG_W'(REG_ZERO);

  state_t state_reg, state_next;
  logic   lu;
  logic   stall_issue;
  logic   flush_issue;

  assign lu = idex_MemRead && (idex_wreg != ZERO_R) &&
              ((id_uses_rs && (id_rs == idex_wreg)) ||
               (id_uses_rt && (id_rt == idex_wreg)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // A taken branch outranks a load-use stall: the stalled instruction is wrong-path.
  always_comb begin
    state_next  = state_reg;
    stall_issue = 1'b0;
    flush_issue = 1'b0;
    case (state_reg)
      RUN: begin
        if (ex_branch_taken) begin
          state_next  = FLUSH;
          flush_issue = 1'b1;
        end else if (lu) begin
          state_next  = STALL;
          stall_issue = 1'b1;
        end
      end
      STALL: begin
        if (ex_branch_taken) begin
          state_next  = FLUSH;
          flush_issue = 1'b1;
        end else begin
          state_next  = RUN;
        end
      end
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign pc_write    = reset && !stall_issue;
  assign ifid_write  = reset && !stall_issue;
  assign ifid_flush  = reset && flush_issue;
  assign idex_bubble = !reset || stall_issue || flush_issue;

  // Operand 0 follows rs (fwd_a), operand 1 follows rt (fwd_b); nearer producer wins.
  logic [REG_W-1:0] src_vec  [2];
  logic [1:0]       fwd_next [2];
  logic [1:0]       fwd_reg  [2];

  assign src_vec[0] = id_rs;
  assign src_vec[1] = id_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_next[gi] = FWD_RF;
        if (idex_RegWrite && (idex_wreg != ZERO_R) && (idex_wreg == src_vec[gi])) begin
          fwd_next[gi] = FWD_EXMEM;
        end else if (exmem_RegWrite && (exmem_wreg != ZERO_R) && (exmem_wreg == src_vec[gi])) begin
          fwd_next[gi] = FWD_MEMWB;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          fwd_reg[gi] <= FWD_RF;
        end else begin
          fwd_reg[gi] <= idex_bubble ? FWD_RF : fwd_next[gi];
        end
      end
    end
  endgenerate

  assign fwd_a = fwd_reg[0];
  assign fwd_b = fwd_reg[1];

  logic             cnt_inc [2];
  logic [CNT_W-1:0] cnt_vec [2];

  assign cnt_inc[0] = stall_issue;
  assign cnt_inc[1] = flush_issue;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc[gi]),
        .clr   (cnt_clear),
        .count (cnt_vec[gi])
      );
    end
  endgenerate

  assign stall_cnt = cnt_vec[0];
  assign flush_cnt = cnt_vec[1];

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed vector bench for hazard_forward_ctrl: a vector table plus
// hand-written sequences for stall/flush, counter saturation and reset.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic       idex_MemRead = 1'b0, idex_RegWrite = 1'b0;
  logic [4:0] idex_wreg = '0;
  logic       exmem_RegWrite = 1'b0;
  logic [4:0] exmem_wreg = '0;
  logic       ex_branch_taken = 1'b0;
  logic       cnt_clear = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_write4, ifid_write4, ifid_flush4, idex_bubble4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_RegWrite(idex_RegWrite), .idex_wreg(idex_wreg),
    .exmem_RegWrite(exmem_RegWrite), .exmem_wreg(exmem_wreg),
    .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_forward_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_RegWrite(idex_RegWrite), .idex_wreg(idex_wreg),
    .exmem_RegWrite(exmem_RegWrite), .exmem_wreg(exmem_wreg),
    .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
    .idex_bubble(idex_bubble4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mr, irw;
    logic [4:0] iw;
    logic       erw;
    logic [4:0] ew;
    logic       br;
    logic       pcw, ifw, fl, bub;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    idex_MemRead = v.mr; idex_RegWrite = v.irw; idex_wreg = v.iw;
    exmem_RegWrite = v.erw; exmem_wreg = v.ew; ex_branch_taken = v.br;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    idex_MemRead = 1'b0; idex_RegWrite = 1'b0; idex_wreg = '0;
    exmem_RegWrite = 1'b0; exmem_wreg = '0; ex_branch_taken = 1'b0;
  endtask

  task automatic chk_ctrl(input string tag, input logic pcw, input logic ifw,
                          input logic fl, input logic bub);
    chk({tag, ".pc_write"},    32'(pc_write),    32'(pcw));
    chk({tag, ".ifid_write"},  32'(ifid_write),  32'(ifw));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rs  rt  urs urt mr irw iw  erw ew  br  pcw ifw fl bub fa     fb
    vecs[0] = '{5'd8, 5'd3, 1, 1, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0, 0, 1, 2'b00, 2'b00}; // load-use rs
    vecs[1] = '{5'd5, 5'd5, 1, 1, 0, 1, 5'd5, 1, 5'd5, 0, 1, 1, 0, 0, 2'b10, 2'b10}; // EX beats MEM
    vecs[2] = '{5'd4, 5'd9, 1, 1, 0, 1, 5'd7, 1, 5'd9, 0, 1, 1, 0, 0, 2'b00, 2'b01}; // MEM only on rt
    vecs[3] = '{5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 1, 5'd0, 0, 1, 1, 0, 0, 2'b00, 2'b00}; // $0 never
    vecs[4] = '{5'd8, 5'd3, 1, 1, 1, 1, 5'd8, 0, 5'd0, 1, 1, 1, 1, 1, 2'b00, 2'b00}; // branch over lu
    vecs[5] = '{5'd1, 5'd8, 1, 0, 1, 1, 5'd8, 0, 5'd0, 0, 1, 1, 0, 0, 2'b00, 2'b10}; // rt unused
    vecs[6] = '{5'd1, 5'd8, 1, 1, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0, 0, 1, 2'b00, 2'b00}; // load-use rt
    vecs[7] = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 1, 1, 1, 1, 2'b00, 2'b00}; // branch only
    vecs[8] = '{5'd6, 5'd7, 1, 1, 0, 1, 5'd7, 1, 5'd6, 0, 1, 1, 0, 0, 2'b01, 2'b10}; // split sources
    vecs[9] = '{5'd3, 5'd2, 1, 1, 0, 0, 5'd3, 1, 5'd3, 0, 1, 1, 0, 0, 2'b01, 2'b00}; // EX no RegWrite

    #3;
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.fwd_a", 32'(fwd_a), 32'd0);
    chk("reset.fwd_b", 32'(fwd_b), 32'd0);
    chk("reset.stall_cnt", stall_cnt, 32'd0);
    chk("reset.flush_cnt", flush_cnt, 32'd0);
    $display("txn reset: pc_write=%0b bubble=%0b", pc_write, idex_bubble);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk_ctrl($sformatf("vec%0d", i), vecs[i].pcw, vecs[i].ifw, vecs[i].fl, vecs[i].bub);
      if (!vecs[i].pcw) exp_stall++;
      if (vecs[i].fl) exp_flush++;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.fwd_a", i), 32'(fwd_a), 32'(vecs[i].fa));
      chk($sformatf("vec%0d.fwd_b", i), 32'(fwd_b), 32'(vecs[i].fb));
      chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, 32'(exp_stall));
      chk($sformatf("vec%0d.flush_cnt", i), flush_cnt, 32'(exp_flush));
      $display("txn vec%0d: pc_write=%0b flush=%0b bubble=%0b fwd_a=%b fwd_b=%b stalls=%0d flushes=%0d",
               i, pc_write, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt);
      @(negedge clk);
      idle();
      @(posedge clk);
    end

    // Stall lasts one cycle even if the load-use pattern is still present.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    exp_stall++;
    @(negedge clk);
    #1;
    chk_ctrl("stall_once", 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("stall_once.stall_cnt", stall_cnt, 32'(exp_stall));
    chk("stall_once.fwd_a", 32'(fwd_a), 32'(2'b10));
    $display("txn stall_once: stalls=%0d fwd_a=%b", stall_cnt, fwd_a);
    @(negedge clk);
    idle();
    @(posedge clk);

    // Taken branch arriving while in STALL flushes.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    exp_stall++;
    @(negedge clk);
    ex_branch_taken = 1'b1;
    #1;
    chk_ctrl("stall_branch", 1'b1, 1'b1, 1'b1, 1'b1);
    exp_flush++;
    @(posedge clk);
    #1;
    chk("stall_branch.stall_cnt", stall_cnt, 32'(exp_stall));
    chk("stall_branch.flush_cnt", flush_cnt, 32'(exp_flush));
    $display("txn stall_branch: stalls=%0d flushes=%0d", stall_cnt, flush_cnt);
    @(negedge clk);
    idle();
    @(posedge clk);

    // Clear both counters.
    @(negedge clk);
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    chk("clear.stall_cnt", stall_cnt, 32'd0);
    chk("clear.flush_cnt", flush_cnt, 32'd0);
    chk("clear.stall_cnt4", 32'(stall_cnt4), 32'd0);
    $display("txn clear: stalls=%0d flushes=%0d stalls4=%0d", stall_cnt, flush_cnt, stall_cnt4);

    // 40 cycles of a held load-use pattern issue 20 stalls (RUN/STALL alternate).
    @(negedge clk);
    drive(vecs[0]);
    repeat (40) @(posedge clk);
    #1;
    chk("sat.stall_cnt", stall_cnt, 32'd20);
    chk("sat.stall_cnt4", 32'(stall_cnt4), 32'd15);
    $display("txn saturate: stalls=%0d stalls4=%0d", stall_cnt, stall_cnt4);

    // Clear wins over an increment in the same cycle.
    @(negedge clk);
    cnt_clear = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    chk("clr_inc.stall_cnt", stall_cnt, 32'd0);
    chk("clr_inc.stall_cnt4", 32'(stall_cnt4), 32'd0);
    $display("txn clear_vs_inc: stalls=%0d stalls4=%0d", stall_cnt, stall_cnt4);

    // Now in STALL: asynchronous reset drops every control to its reset value.
    #2;
    reset = 1'b0;
    #1;
    chk_ctrl("rst_stall", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_stall.fwd_a", 32'(fwd_a), 32'd0);
    $display("txn reset_in_stall: pc_write=%0b bubble=%0b", pc_write, idex_bubble);
    @(negedge clk);
    reset = 1'b1;
    #1;
    // Held load-use stalls right away, which only happens from RUN.
    chk_ctrl("rst_release", 1'b0, 1'b0, 1'b0, 1'b1);
    $display("txn reset_release: pc_write=%0b bubble=%0b", pc_write, idex_bubble);
    @(posedge clk);
    #1;
    chk("rst_release.stall_cnt", stall_cnt, 32'd1);
    @(negedge clk);
    idle();
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Control partner of the ID/EX pipeline register in the 5-stage MIPS core.
- Watches the instruction in ID and the producers held in ID/EX, EX/MEM and MEM/WB.
- Drives the stall, flush and bubble controls that govern ID/EX and IF/ID.
- Produces registered forwarding selects that become valid in EX together with the ID/EX outputs.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 32, width of each event counter.
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_uses_rs  in  1  the ID instruction reads rs.
- id_uses_rt  in  1  the ID instruction reads rt as a source.
- idex_MemRead  in  1  the instruction in EX is a load.
- idex_RegWrite  in  1  the instruction in EX writes a register.
- idex_wreg  in  REG_W  destination register of the instruction in EX (after RegDst mux).
- exmem_RegWrite  in  1  the instruction in MEM writes a register.
- exmem_wreg  in  REG_W  destination register of the instruction in MEM.
- ex_branch_taken  in  1  BranchEQ resolved taken in EX this cycle.
- cnt_clear  in  1  synchronous clear of both counters.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  force all ID/EX control bits to 0 on the next edge.
- fwd_a  out  2  EX operand-A select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- fwd_b  out  2  EX operand-B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low.
- Reset values: state = RUN, fwd_a = fwd_b = 00, stall_cnt = flush_cnt = 0.
  - pc_write = 0, ifid_write = 0, ifid_flush = 0, idex_bubble = 1 while reset is low.
- Load-use hazard (combinational), lu:
  - idex_MemRead && idex_wreg != 0 && ((id_uses_rs && id_rs == idex_wreg) || (id_uses_rt && id_rt == idex_wreg)).
- FSM states: RUN, STALL, FLUSH.
  - RUN:
    - ex_branch_taken → FLUSH. Branch has priority over lu, since the stalled instruction is wrong-path.
    - Else lu → STALL.
    - Else stay in RUN.
  - STALL: lasts exactly one cycle. Then ex_branch_taken → FLUSH, else → RUN.
    - A load in EX cannot still be a load-use hazard after a bubble, so there is no back-to-back stall.
  - FLUSH: lasts exactly one cycle, → RUN.
- Outputs (combinational from the next-state decision in the current cycle):
  - Stall decision: pc_write = 0, ifid_write = 0, idex_bubble = 1, ifid_flush = 0.
  - Branch-taken decision: pc_write = 1, ifid_write = 1, ifid_flush = 1, idex_bubble = 1. Both wrong-path instructions (IF and ID) are squashed.
  - Otherwise: pc_write = 1, ifid_write = 1, ifid_flush = 0, idex_bubble = 0.
- Forwarding (registered, 1-cycle latency, aligned with ID/EX):
  - At each clock edge, fwd_a is computed for id_rs:
    - 10 if idex_RegWrite && idex_wreg != 0 && idex_wreg == id_rs. That producer is in MEM when the consumer reaches EX.
    - Else 01 if exmem_RegWrite && exmem_wreg != 0 && exmem_wreg == id_rs.
    - Else 00.
  - fwd_b is computed the same way using id_rt.
  - The nearer producer always wins.
  - fwd_a and fwd_b load 00 on any edge where idex_bubble = 1.
  - Register $0 is never forwarded.
- Counters:
  - stall_cnt increments on each cycle a stall is issued.
  - flush_cnt increments on each cycle a taken-branch flush is issued.
  - Both saturate at all-ones.
  - cnt_clear has priority over increment: the counter reads 0 on the next cycle.
- Reset mid-stall or mid-flush: the asynchronous return to RUN takes effect immediately, and all outputs go to their reset values.

Decomposition:
- Shared package pipeline_pkg:
  - FWD_RF = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01.
  - State encoding RUN/STALL/FLUSH.
  - REG_ZERO = 5'd0.
- One sub-module sat_counter (CNT_W, inc, clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use hazard: lw $8 in EX (idex_MemRead = 1, idex_wreg = 8); ID add uses rs = 8.
  - → one cycle of pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_cnt = 1.
  - Next cycle: RUN and no stall.
- EX-forward priority: idex_RegWrite = 1, idex_wreg = 5, exmem_RegWrite = 1, exmem_wreg = 5, id_rs = 5, id_rt = 5, no load.
  - → after the edge, fwd_a = 10 and fwd_b = 10.
- MEM-forward: only exmem_wreg = 9 matches id_rt = 9.
  - → fwd_b = 01 and fwd_a = 00.
- Register $0: wreg = 0 with a RegWrite match.
  - → fwd_a = fwd_b = 00 and no stall.
- Branch over load-use: lu and ex_branch_taken asserted in the same cycle.
  - → ifid_flush = 1, idex_bubble = 1, pc_write = 1; flush_cnt = 1, stall_cnt unchanged.
- Counter saturation, clear and reset:
  - Preload near max with CNT_W = 4 and issue 20 stalls → stall_cnt holds 15.
  - Assert cnt_clear → stall_cnt = 0.
  - Drop reset during STALL → idex_bubble = 1 and pc_write = 0 immediately; RUN after release.
